trig_sequencer: RTL and testbench
=================================

TRIG_SEQUENCER -- requirements
Module: trig_sequencer

Interface
REQ-001 Parameters: none; the table depth is fixed at 4 entries.
REQ-002 Clock and reset: one clock; reset is synchronous and active-high.
REQ-003 clk  in  1  system clock; all logic is on the rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 cfg_we  in  1  table write strobe, one cycle.
REQ-006 cfg_addr  in  2  table entry index, 0..3.
REQ-007 cfg_ptn  in  3  pattern field of the entry.
REQ-008 cfg_gap  in  12  gap field of the entry.
REQ-009 cfg_ntrig  in  16  trigger-count field of the entry; 0 marks the entry as empty.
REQ-010 start  in  1  one-cycle pulse that begins a pass over entries 0..3.
REQ-011 abort  in  1  one-cycle pulse that stops the sequence.
REQ-012 loop  in  1  when 1, the sequence restarts at entry 0 after entry 3.
REQ-013 fac_rst  out  1  reset to the trigger generator.
REQ-014 fac_ena  out  1  enable to the trigger generator.
REQ-015 fac_trig_ptn  out  3  pattern to the generator.
REQ-016 fac_gap  out  12  gap to the generator.
REQ-017 fac_ntrig  out  16  trigger count to the generator.
REQ-018 busy  out  1  high in every state except IDLE.
REQ-019 cur_entry  out  2  index of the entry being run.
REQ-020 seq_done  out  1  one-cycle pulse when a non-looping pass completes or is aborted.
REQ-021 cfg_err  out  1  one-cycle pulse when a write is rejected.

Function
REQ-022 All outputs are registered.
REQ-023 The table is 4 x {ptn[2:0], gap[11:0], ntrig[15:0]} and is written only when the state is IDLE.
REQ-024 A cfg_we that arrives while busy=1 is dropped: the table is unchanged and cfg_err pulses on the next cycle.
REQ-025 The FSM states are IDLE, SEL, LOAD, RUN and FIN.
REQ-026 IDLE: on start=1, the next state is SEL with the entry pointer at 0; start is ignored when busy=1.
REQ-027 SEL (1 cycle): if the table ntrig at the pointer is 0, the entry is skipped to its successor; otherwise the FSM goes to LOAD and cur_entry takes the pointer value.
REQ-028 Successor of entry 3: SEL at entry 0 when loop=1, otherwise FIN.
REQ-029 If all 4 entries are empty, a pass takes 4 SEL cycles and then goes to FIN.
REQ-030 With loop=1 and all 4 entries empty, the FSM goes to FIN after one pass so it cannot spin forever.
REQ-031 LOAD (1 cycle): fac_rst=1, fac_ena=0, and the fac_* config outputs take the entry fields.
REQ-032 LOAD clamp: fac_gap = max(gap, 1), because a gap of 0 is not a valid generator setting.
REQ-033 RUN: fac_ena=1 and fac_rst=0 for exactly ntrig*(G+4) cycles, where G is the clamped gap.
REQ-034 The RUN duration is tracked with a 13-bit frame counter (0..G+3) and a 16-bit trigger counter; no multiplier is used.
REQ-035 In the last RUN cycle, the next state is SEL at the successor entry and fac_ena falls on the following cycle.
REQ-036 fac_trig_ptn, fac_gap and fac_ntrig are held constant from LOAD until the next LOAD or reset.
REQ-037 FIN (1 cycle): seq_done=1, fac_ena=0, then the FSM goes to IDLE.
REQ-038 abort=1 in any non-IDLE state forces FIN on the next cycle, with fac_ena=0 from that cycle onward.
REQ-039 abort takes priority over every other transition, including the RUN-end transition.
REQ-040 abort=1 in IDLE has no effect.
REQ-041 If start and abort are asserted together in IDLE, abort wins and the FSM stays in IDLE.
REQ-042 A change of the loop input is sampled only at the entry-3 successor decision.
REQ-043 Counter widths: frame counter 13 bits (maximum 4098), trigger counter 16 bits (maximum 65535); neither counter wraps during RUN.

Reset
REQ-044 rst=1 sets state=IDLE, busy=0, fac_ena=0 and fac_rst=1.
REQ-045 rst=1 clears fac_trig_ptn, fac_gap, fac_ntrig, cur_entry, seq_done, cfg_err, the entry pointer and both counters to 0.
REQ-046 rst=1 clears every table ntrig field to 0, which marks all entries empty.
REQ-047 fac_rst returns to 0 on the first cycle after rst deasserts.
REQ-048 rst asserted mid-RUN takes effect on the next edge and overrides abort and start.

Verification
REQ-049 Entry0={ptn=3'b101, gap=10, ntrig=3}, others empty, start, loop=0 -> LOAD 1 cycle with fac_rst=1; fac_ena high for exactly 42 cycles; 3 SEL skips; seq_done 1 cycle; busy low after FIN.
REQ-050 Entry1={gap=0, ntrig=2}, entry3={gap=5, ntrig=1}, start -> fac_gap=1 for entry 1 with RUN of 10 cycles; then LOAD entry 3 with RUN of 9 cycles; cur_entry goes 1 then 3.
REQ-051 Entry0={gap=2, ntrig=1}, loop=1, start -> RUN of 6 cycles repeats with an identical LOAD/RUN period each pass; abort mid-RUN -> fac_ena=0 next cycle, seq_done pulse, IDLE.
REQ-052 cfg_we to entry 2 while busy -> cfg_err pulse, table unchanged; a read-back run of entry 2 shows its old ntrig.
REQ-053 rst asserted on the 5th RUN cycle -> next cycle IDLE, fac_rst=1, fac_ena=0, all table entries empty; a later start gives 4 SEL cycles, FIN and seq_done.
REQ-054 Simultaneous start+abort in IDLE -> stays IDLE with no seq_done; entry0={gap=4095, ntrig=65535} -> RUN length 65535*4099 cycles with no counter wrap (checked by a counter probe at the boundary).

Source files
------------

// File: rtl/trig_sequencer.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | trig_sequencer : steps a 4-entry table of trigger settings into a generator |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
module trig_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        cfg_we,
  input  logic [1:0]  cfg_addr,
  input  logic [2:0]  cfg_ptn,
  input  logic [11:0] cfg_gap,
  input  logic [15:0] cfg_ntrig,
  input  logic        start,
  input  logic        abort,
  input  logic        loop,
  output logic        fac_rst,
  output logic        fac_ena,
  output logic [2:0]  fac_trig_ptn,
  output logic [11:0] fac_gap,
  output logic [15:0] fac_ntrig,
  output logic        busy,
  output logic [1:0]  cur_entry,
  output logic        seq_done,
  output logic        cfg_err
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SEL  = 3'd1,
    ST_LOAD = 3'd2,
    ST_RUN  = 3'd3,
    ST_FIN  = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  ptr_q, ptr_d;
  logic        hit_q, hit_d;
  logic [12:0] frm_q, frm_d;
  logic [15:0] tcnt_q, tcnt_d;

  logic [2:0]  tbl_ptn_q   [4];
  logic [2:0]  tbl_ptn_d   [4];
  logic [11:0] tbl_gap_q   [4];
  logic [11:0] tbl_gap_d   [4];
  logic [15:0] tbl_ntrig_q [4];
  logic [15:0] tbl_ntrig_d [4];

  logic        fac_rst_q, fac_rst_d;
  logic        fac_ena_q, fac_ena_d;
  logic [2:0]  fac_ptn_q, fac_ptn_d;
  logic [11:0] fac_gap_q, fac_gap_d;
  logic [15:0] fac_ntrig_q, fac_ntrig_d;
  logic        busy_q, busy_d;
  logic [1:0]  cur_entry_q, cur_entry_d;
  logic        seq_done_q, seq_done_d;
  logic        cfg_err_q, cfg_err_d;

  state_t      w_adv_state;
  logic [12:0] w_frm_last;
  logic [15:0] w_tcnt_last;

  // Successor of the current pointer; a pass that found nothing never loops.
  always_comb begin
    w_adv_state = ST_SEL;
    if (ptr_q == 2'd3 && !(loop && hit_q)) begin
      w_adv_state = ST_FIN;
    end
    w_frm_last  = {1'b0, fac_gap_q} + 13'd3;
    w_tcnt_last = fac_ntrig_q - 16'd1;
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    hit_d       = hit_q;
    frm_d       = frm_q;
    tcnt_d      = tcnt_q;
    tbl_ptn_d   = tbl_ptn_q;
    tbl_gap_d   = tbl_gap_q;
    tbl_ntrig_d = tbl_ntrig_q;
    fac_ptn_d   = fac_ptn_q;
    fac_gap_d   = fac_gap_q;
    fac_ntrig_d = fac_ntrig_q;
    cur_entry_d = cur_entry_q;
    cfg_err_d   = 1'b0;

    if (cfg_we) begin
      if (state_q == ST_IDLE) begin
        tbl_ptn_d[cfg_addr]   = cfg_ptn;
        tbl_gap_d[cfg_addr]   = cfg_gap;
        tbl_ntrig_d[cfg_addr] = cfg_ntrig;
      end else begin
        cfg_err_d = 1'b1;
      end
    end

    if (abort && state_q != ST_IDLE) begin
      state_d = ST_FIN;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start && !abort) begin
            state_d = ST_SEL;
            ptr_d   = 2'd0;
            hit_d   = 1'b0;
          end
        end
        ST_SEL: begin
          if (tbl_ntrig_q[ptr_q] == 16'd0) begin
            state_d = w_adv_state;
            ptr_d   = ptr_q + 2'd1;
          end else begin
            state_d     = ST_LOAD;
            hit_d       = 1'b1;
            cur_entry_d = ptr_q;
            fac_ptn_d   = tbl_ptn_q[ptr_q];
            fac_gap_d   = (tbl_gap_q[ptr_q] == 12'd0) ? 12'd1 : tbl_gap_q[ptr_q];
            fac_ntrig_d = tbl_ntrig_q[ptr_q];
          end
        end
        ST_LOAD: begin
          state_d = ST_RUN;
          frm_d   = 13'd0;
          tcnt_d  = 16'd0;
        end
        ST_RUN: begin
          // One frame is G+4 cycles; ntrig frames make up the whole run.
          if (frm_q == w_frm_last) begin
            frm_d = 13'd0;
            if (tcnt_q == w_tcnt_last) begin
              state_d = w_adv_state;
              ptr_d   = ptr_q + 2'd1;
            end else begin
              tcnt_d = tcnt_q + 16'd1;
            end
          end else begin
            frm_d = frm_q + 13'd1;
          end
        end
        ST_FIN:  state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end

    fac_rst_d  = (state_d == ST_LOAD);
    fac_ena_d  = (state_d == ST_RUN);
    seq_done_d = (state_d == ST_FIN);
    busy_d     = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      ptr_q       <= 2'd0;
      hit_q       <= 1'b0;
      frm_q       <= 13'd0;
      tcnt_q      <= 16'd0;
      tbl_ptn_q   <= '{default: 3'd0};
      tbl_gap_q   <= '{default: 12'd0};
      tbl_ntrig_q <= '{default: 16'd0};
      fac_rst_q   <= 1'b1;
      fac_ena_q   <= 1'b0;
      fac_ptn_q   <= 3'd0;
      fac_gap_q   <= 12'd0;
      fac_ntrig_q <= 16'd0;
      busy_q      <= 1'b0;
      cur_entry_q <= 2'd0;
      seq_done_q  <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      hit_q       <= hit_d;
      frm_q       <= frm_d;
      tcnt_q      <= tcnt_d;
      tbl_ptn_q   <= tbl_ptn_d;
      tbl_gap_q   <= tbl_gap_d;
      tbl_ntrig_q <= tbl_ntrig_d;
      fac_rst_q   <= fac_rst_d;
      fac_ena_q   <= fac_ena_d;
      fac_ptn_q   <= fac_ptn_d;
      fac_gap_q   <= fac_gap_d;
      fac_ntrig_q <= fac_ntrig_d;
      busy_q      <= busy_d;
      cur_entry_q <= cur_entry_d;
      seq_done_q  <= seq_done_d;
      cfg_err_q   <= cfg_err_d;
    end
  end

  assign fac_rst      = fac_rst_q;
  assign fac_ena      = fac_ena_q;
  assign fac_trig_ptn = fac_ptn_q;
  assign fac_gap      = fac_gap_q;
  assign fac_ntrig    = fac_ntrig_q;
  assign busy         = busy_q;
  assign cur_entry    = cur_entry_q;
  assign seq_done     = seq_done_q;
  assign cfg_err      = cfg_err_q;

endmodule
`default_nettype wire

// File: tb/tb_trig_sequencer.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tb_trig_sequencer : directed self-checking bench for trig_sequencer         |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
module tb_trig_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_we = 1'b0;
  logic [1:0]  cfg_addr = 2'd0;
  logic [2:0]  cfg_ptn = 3'd0;
  logic [11:0] cfg_gap = 12'd0;
  logic [15:0] cfg_ntrig = 16'd0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        loop = 1'b0;
  logic        fac_rst, fac_ena, busy, seq_done, cfg_err;
  logic [2:0]  fac_trig_ptn;
  logic [11:0] fac_gap;
  logic [15:0] fac_ntrig;
  logic [1:0]  cur_entry;

  int total = 0;
  int bad   = 0;
  int n;
  int k;

  trig_sequencer dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_ptn(cfg_ptn), .cfg_gap(cfg_gap), .cfg_ntrig(cfg_ntrig),
    .start(start), .abort(abort), .loop(loop),
    .fac_rst(fac_rst), .fac_ena(fac_ena), .fac_trig_ptn(fac_trig_ptn),
    .fac_gap(fac_gap), .fac_ntrig(fac_ntrig), .busy(busy),
    .cur_entry(cur_entry), .seq_done(seq_done), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [2:0] p, input logic [11:0] g,
                    input logic [15:0] t);
    cfg_we = 1'b1; cfg_addr = a; cfg_ptn = p; cfg_gap = g; cfg_ntrig = t;
    step();
    cfg_we = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_load(input string tag, input logic [2:0] p, input logic [11:0] g,
                           input logic [15:0] t, input logic [1:0] e);
    int w = 0;
    while (!fac_rst && w < 100) begin step(); w++; end
    chk({tag, "_rst"},   fac_rst, 1);
    chk({tag, "_ena"},   fac_ena, 0);
    chk({tag, "_ptn"},   fac_trig_ptn, p);
    chk({tag, "_gap"},   fac_gap, g);
    chk({tag, "_ntrig"}, fac_ntrig, t);
    chk({tag, "_entry"}, cur_entry, e);
  endtask

  task automatic count_ena(output int c);
    int w = 0;
    while (!fac_ena && w < 20) begin step(); w++; end
    c = 0;
    while (fac_ena && c < 1000) begin c++; step(); end
  endtask

  task automatic wait_done(output int c);
    c = 0;
    while (!seq_done && c < 50) begin step(); c++; end
  endtask

  initial begin
    // Reset behaviour
    step(); step();
    chk("rst_busy", busy, 0);
    chk("rst_facrst", fac_rst, 1);
    chk("rst_ena", fac_ena, 0);
    chk("rst_gap", fac_gap, 0);
    chk("rst_done", seq_done, 0);
    rst = 1'b0;
    step();
    chk("rst_release_facrst", fac_rst, 0);

    // Single entry 0, three skipped entries
    wr(2'd0, 3'b101, 12'd10, 16'd3);
    chk("idle_wr_noerr", cfg_err, 0);
    pulse_start();
    chk("t1_busy", busy, 1);
    wait_load("t1", 3'b101, 12'd10, 16'd3, 2'd0);
    count_ena(n);
    chk("t1_runlen", n, 42);
    wait_done(k);
    chk("t1_skips", k, 3);
    step();
    chk("t1_done_pulse", seq_done, 0);
    chk("t1_idle", busy, 0);

    // Gap clamp on entry 1, then entry 3
    wr(2'd0, 3'd0, 12'd0, 16'd0);
    wr(2'd1, 3'd2, 12'd0, 16'd2);
    wr(2'd3, 3'd7, 12'd5, 16'd1);
    pulse_start();
    wait_load("t2a", 3'd2, 12'd1, 16'd2, 2'd1);
    count_ena(n);
    chk("t2a_runlen", n, 10);
    wait_load("t2b", 3'd7, 12'd5, 16'd1, 2'd3);
    count_ena(n);
    chk("t2b_runlen", n, 9);
    wait_done(k);
    chk("t2_fin_direct", k, 0);
    step();
    chk("t2_idle", busy, 0);

    // Looping pass with abort mid-run
    wr(2'd1, 3'd0, 12'd0, 16'd0);
    wr(2'd3, 3'd0, 12'd0, 16'd0);
    wr(2'd0, 3'd4, 12'd2, 16'd1);
    loop = 1'b1;
    pulse_start();
    wait_load("t3", 3'd4, 12'd2, 16'd1, 2'd0);
    for (int pass = 0; pass < 2; pass++) begin
      count_ena(n);
      chk("t3_runlen", n, 6);
      k = 0;
      while (!fac_rst && k < 50) begin step(); k++; end
      chk("t3_period_gap", k, 4);
    end
    count_ena(n);
    chk("t3_runlen_last", n, 6);
    k = 0;
    while (!fac_ena && k < 50) begin step(); k++; end
    step(); step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("t3_abort_ena", fac_ena, 0);
    chk("t3_abort_done", seq_done, 1);
    step();
    chk("t3_abort_idle", busy, 0);
    loop = 1'b0;

    // Write while busy is rejected
    wr(2'd2, 3'd3, 12'd3, 16'd4);
    pulse_start();
    chk("t4_busy", busy, 1);
    cfg_we = 1'b1; cfg_addr = 2'd2; cfg_ptn = 3'd0; cfg_gap = 12'd7; cfg_ntrig = 16'd9;
    step();
    cfg_we = 1'b0;
    chk("t4_cfg_err", cfg_err, 1);
    chk("t4_load0", fac_rst, 1);
    count_ena(n);
    chk("t4_cfg_err_clear", cfg_err, 0);
    chk("t4_runlen0", n, 6);
    wait_load("t4", 3'd3, 12'd3, 16'd4, 2'd2);
    count_ena(n);
    chk("t4_runlen2", n, 28);
    wait_done(k);
    chk("t4_fin", k, 1);
    step();
    chk("t4_idle", busy, 0);

    // Reset on the fifth RUN cycle, overriding abort and start
    pulse_start();
    wait_load("t5", 3'd4, 12'd2, 16'd1, 2'd0);
    step();
    chk("t5_run1", fac_ena, 1);
    repeat (4) step();
    chk("t5_run5", fac_ena, 1);
    rst = 1'b1; abort = 1'b1; start = 1'b1;
    step();
    rst = 1'b0; abort = 1'b0; start = 1'b0;
    chk("t5_busy", busy, 0);
    chk("t5_facrst", fac_rst, 1);
    chk("t5_ena", fac_ena, 0);
    chk("t5_gap", fac_gap, 0);
    chk("t5_done", seq_done, 0);
    step();
    chk("t5_facrst_rel", fac_rst, 0);
    pulse_start();
    wait_done(k);
    chk("t5_empty_sel", k, 4);
    chk("t5_empty_noena", fac_ena, 0);
    step();
    chk("t5_idle", busy, 0);

    // Start and abort together in IDLE
    start = 1'b1; abort = 1'b1;
    step();
    start = 1'b0; abort = 1'b0;
    chk("t6_stay_idle", busy, 0);
    step();
    chk("t6_no_done", seq_done, 0);
    chk("t6_still_idle", busy, 0);

    // Widest entry: frame counter reaches G+3 = 4098 and rolls into the next trigger
    wr(2'd0, 3'd1, 12'd4095, 16'd65535);
    pulse_start();
    wait_load("t7", 3'd1, 12'd4095, 16'd65535, 2'd0);
    step();
    chk("t7_ena", fac_ena, 1);
    chk("t7_frm0", dut.frm_q, 0);
    repeat (4098) step();
    chk("t7_frm_max", dut.frm_q, 4098);
    chk("t7_tcnt0", dut.tcnt_q, 0);
    step();
    chk("t7_frm_roll", dut.frm_q, 0);
    chk("t7_tcnt1", dut.tcnt_q, 1);
    chk("t7_ena_hold", fac_ena, 1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("t7_abort_done", seq_done, 1);
    chk("t7_abort_ena", fac_ena, 0);
    step();
    chk("t7_idle", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
